// File: rtl/awb_pkg.sv
// Shared types and helpers for the gray-world auto white balance block.
package awb_pkg;

    localparam int FRAC_DEF   = 10;
    localparam int GAIN_W_DEF = FRAC_DEF + 2;
    localparam int GAIN_ONE   = 1 << FRAC_DEF;
    localparam int GAIN_MAX   = (1 << GAIN_W_DEF) - 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DIV_R = 2'd1,
        DIV_B = 2'd2,
        DONE  = 2'd3
    } awb_state_e;

    // Unsigned saturation of value to dw bits.
    function automatic logic [63:0] sat_u(input logic [63:0] value, input int dw);
        logic [63:0] lim;
        lim = (64'd1 << dw) - 64'd1;
        return (value > lim) ? lim : value;
    endfunction

endpackage

// File: rtl/awb_seq_div.sv
// Restoring sequential divider, one quotient bit per cycle, start/done/busy handshake.
module awb_seq_div #(
    parameter int              NW     = 42,
    parameter int              DVW    = 32,
    parameter logic [NW-1:0]   DIV0_Q = '1
) (
    input  logic           CLK,
    input  logic           RST_n,
    input  logic           start_i,
    input  logic [NW-1:0]  num_i,
    input  logic [DVW-1:0] den_i,
    output logic [NW-1:0]  quo_o,
    output logic           busy_o,
    output logic           done_o
);

    localparam int CW = $clog2(NW + 1);

    logic [DVW-1:0] rem_q;
    logic [DVW-1:0] den_q;
    logic [NW-1:0]  quo_q;
    logic [CW-1:0]  cnt_q;
    logic           busy_q;
    logic           done_q;

    logic [DVW:0]   trial;
    logic [DVW:0]   diff;
    logic           qbit;

    // Partial remainder shifted left with the next numerator bit; one extra bit of headroom.
    always_comb begin
        trial = {rem_q, quo_q[NW-1]};
        diff  = trial - {1'b0, den_q};
        qbit  = (trial >= {1'b0, den_q});
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            rem_q  <= '0;
            den_q  <= '0;
            quo_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start_i && !busy_q) begin
                if (den_i == '0) begin
                    quo_q  <= DIV0_Q;
                    done_q <= 1'b1;
                end else begin
                    rem_q  <= '0;
                    quo_q  <= num_i;
                    den_q  <= den_i;
                    cnt_q  <= CW'(NW);
                    busy_q <= 1'b1;
                end
            end else if (busy_q) begin
                rem_q <= qbit ? diff[DVW-1:0] : trial[DVW-1:0];
                quo_q <= {quo_q[NW-2:0], qbit};
                cnt_q <= cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign quo_o  = quo_q;
    assign busy_o = busy_q;
    assign done_o = done_q;

endmodule

// File: rtl/awb_gray_world_div.sv
// Gray-world auto white balance: per-frame channel sums, R/B gains via a shared divider.
// Define AWB_SMOOTH_EN to blend new gains into the pending gains with an IIR step.
module awb_gray_world_div
    import awb_pkg::*;
#(
    parameter int DW     = 8,
    parameter int FRAC   = FRAC_DEF,
    parameter int GAIN_W = FRAC + 2,
    parameter int SUM_W  = 32
`ifdef AWB_SMOOTH_EN
    ,
    parameter int SMOOTH_SH = 2
`endif
) (
    input  logic              CLK,
    input  logic              RST_n,
    input  logic              iEN,
    input  logic              iFVAL,
    input  logic              iLVAL,
    input  logic [DW-1:0]     iR,
    input  logic [DW-1:0]     iG,
    input  logic [DW-1:0]     iB,
    output logic              oFVAL,
    output logic              oLVAL,
    output logic [DW-1:0]     oR,
    output logic [DW-1:0]     oG,
    output logic [DW-1:0]     oB,
    output logic [GAIN_W-1:0] oRgain,
    output logic [GAIN_W-1:0] oBgain,
    output logic              oBusy,
    output logic              oDrop
);

    localparam int                NW    = SUM_W + FRAC;
    localparam int                PW    = DW + GAIN_W;
    localparam logic [GAIN_W-1:0] G_ONE = GAIN_W'(1) << FRAC;
    localparam logic [GAIN_W-1:0] G_MAX = '1;

    logic              fval_q;
    logic              rise;
    logic              fall;
    logic              pix_v;
    logic [SUM_W-1:0]  rsum_q, rsum_d;
    logic [SUM_W-1:0]  gsum_q, gsum_d;
    logic [SUM_W-1:0]  bsum_q, bsum_d;
    logic [SUM_W-1:0]  cnt_q, cnt_d;

    awb_state_e        state_q;
    logic              start_q;
    logic              drop_q;
    logic [SUM_W-1:0]  lat_r_q, lat_g_q, lat_b_q;
    logic [GAIN_W-1:0] qr_q, qb_q;
    logic [GAIN_W-1:0] pend_r_q, pend_b_q;
    logic [GAIN_W-1:0] act_r_q, act_b_q;
    logic [GAIN_W-1:0] upd_r, upd_b;
    logic [GAIN_W-1:0] q_clamped;
    logic              apply;

    logic [NW-1:0]     div_num;
    logic [SUM_W-1:0]  div_den;
    logic [NW-1:0]     div_quo;
    logic              div_busy;
    logic              div_done;

    logic [GAIN_W-1:0] eff_r, eff_b;
    logic [GAIN_W-1:0] use_r, use_b;
    logic [PW-1:0]     p_r_q, p_g_q, p_b_q;
    logic              fv1_q, lv1_q;

    assign rise  = iFVAL & ~fval_q;
    assign fall  = ~iFVAL & fval_q;
    assign pix_v = iFVAL & iLVAL;
    assign apply = rise && (state_q == IDLE);

    always_comb begin
        rsum_d = rise ? '0 : rsum_q;
        gsum_d = rise ? '0 : gsum_q;
        bsum_d = rise ? '0 : bsum_q;
        cnt_d  = rise ? '0 : cnt_q;
        if (pix_v) begin
            rsum_d = rsum_d + SUM_W'(iR);
            gsum_d = gsum_d + SUM_W'(iG);
            bsum_d = bsum_d + SUM_W'(iB);
            cnt_d  = cnt_d + SUM_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            fval_q <= 1'b0;
            rsum_q <= '0;
            gsum_q <= '0;
            bsum_q <= '0;
            cnt_q  <= '0;
        end else begin
            fval_q <= iFVAL;
            rsum_q <= rsum_d;
            gsum_q <= gsum_d;
            bsum_q <= bsum_d;
            cnt_q  <= cnt_d;
        end
    end

    assign div_num   = {lat_g_q, {FRAC{1'b0}}};
    assign div_den   = (state_q == DIV_B) ? lat_b_q : lat_r_q;
    assign q_clamped = (div_quo > NW'(G_MAX)) ? G_MAX : div_quo[GAIN_W-1:0];

    awb_seq_div #(
        .NW     (NW),
        .DVW    (SUM_W),
        .DIV0_Q (NW'(G_MAX))
    ) u_div (
        .CLK     (CLK),
        .RST_n   (RST_n),
        .start_i (start_q),
        .num_i   (div_num),
        .den_i   (div_den),
        .quo_o   (div_quo),
        .busy_o  (div_busy),
        .done_o  (div_done)
    );

`ifdef AWB_SMOOTH_EN
    logic signed [GAIN_W+1:0] dr, db;
    always_comb begin
        dr    = $signed({2'b00, qr_q}) - $signed({2'b00, pend_r_q});
        db    = $signed({2'b00, qb_q}) - $signed({2'b00, pend_b_q});
        upd_r = pend_r_q + GAIN_W'(dr >>> SMOOTH_SH);
        upd_b = pend_b_q + GAIN_W'(db >>> SMOOTH_SH);
    end
`else
    always_comb begin
        upd_r = qr_q;
        upd_b = qb_q;
    end
`endif

    // Frame-end sequencing: latch sums, divide R then B, publish to pending gains.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q  <= IDLE;
            start_q  <= 1'b0;
            drop_q   <= 1'b0;
            lat_r_q  <= '0;
            lat_g_q  <= '0;
            lat_b_q  <= '0;
            qr_q     <= G_ONE;
            qb_q     <= G_ONE;
            pend_r_q <= G_ONE;
            pend_b_q <= G_ONE;
            act_r_q  <= G_ONE;
            act_b_q  <= G_ONE;
        end else begin
            start_q <= 1'b0;
            drop_q  <= fall && (state_q != IDLE);
            case (state_q)
                IDLE: begin
                    if (fall && (cnt_q != '0)) begin
                        lat_r_q <= rsum_q;
                        lat_g_q <= gsum_q;
                        lat_b_q <= bsum_q;
                        start_q <= 1'b1;
                        state_q <= DIV_R;
                    end
                end
                DIV_R: begin
                    if (div_done) begin
                        qr_q    <= q_clamped;
                        start_q <= 1'b1;
                        state_q <= DIV_B;
                    end
                end
                DIV_B: begin
                    if (div_done) begin
                        qb_q    <= q_clamped;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    pend_r_q <= upd_r;
                    pend_b_q <= upd_b;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
            if (apply) begin
                act_r_q <= pend_r_q;
                act_b_q <= pend_b_q;
            end
        end
    end

    // A pixel arriving on the FVAL-rise cycle already sees the new frame's gains.
    assign eff_r = apply ? pend_r_q : act_r_q;
    assign eff_b = apply ? pend_b_q : act_b_q;
    assign use_r = iEN ? eff_r : G_ONE;
    assign use_b = iEN ? eff_b : G_ONE;

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            p_r_q <= '0;
            p_g_q <= '0;
            p_b_q <= '0;
            fv1_q <= 1'b0;
            lv1_q <= 1'b0;
            oR    <= '0;
            oG    <= '0;
            oB    <= '0;
            oFVAL <= 1'b0;
            oLVAL <= 1'b0;
        end else begin
            p_r_q <= PW'(iR) * PW'(use_r);
            p_g_q <= PW'(iG) * PW'(G_ONE);
            p_b_q <= PW'(iB) * PW'(use_b);
            fv1_q <= iFVAL;
            lv1_q <= iLVAL;
            oR    <= DW'(sat_u(64'(p_r_q >> FRAC), DW));
            oG    <= DW'(sat_u(64'(p_g_q >> FRAC), DW));
            oB    <= DW'(sat_u(64'(p_b_q >> FRAC), DW));
            oFVAL <= fv1_q;
            oLVAL <= lv1_q;
        end
    end

    assign oRgain = act_r_q;
    assign oBgain = act_b_q;
    assign oBusy  = (state_q != IDLE) | div_busy;
    assign oDrop  = drop_q;

endmodule
